// File: rtl/xl_sender.sv
// -----------------------------------------------------------------------------
// xl_sender
//
// Purpose:
//   Serial frame transmitter. A sampled start request sends the 7-bit PATTERN
//   MSB first on dout, one bit per cycle. The line is then held idle-high for
//   GAP cycles before the next frame may begin. done pulses for one cycle at
//   the start of the gap, and frame_cnt counts completed frames, wrapping
//   from 255 to 0.
//
// Parameters:
//   PATTERN  7-bit frame pattern, transmitted MSB first
//   GAP      idle-high cycles after each frame (legal range 1..15)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   frame request, level-sampled on rising clk edges
//   dout       out  serial line, idle level 1 (registered)
//   busy       out  high during frame bits and gap cycles (registered)
//   done       out  one-cycle pulse in the first gap cycle (registered)
//   frame_cnt  out  8-bit count of completed frames (registered)
//
// Configuration:
//   XL_SENDER_BURST_EN  when defined, start sampled at the edge that ends the
//                       last gap cycle begins the next frame directly, with no
//                       idle cycle in between. When undefined, start is
//                       sampled only in IDLE, so at least one idle cycle
//                       always separates frames.
// -----------------------------------------------------------------------------
module xl_sender #(
  parameter logic [6:0] PATTERN = 7'b010_0010,
  parameter int         GAP     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       dout,
  output logic       busy,
  output logic       done,
  output logic [7:0] frame_cnt
);

  // Reject gap lengths that cannot be represented by the 4-bit gap counter.
  if (GAP < 1 || GAP > 15) begin : g_bad_gap
    $error("xl_sender: GAP must be in the range 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  state_t     state;
  logic [2:0] idx;
  logic [3:0] gap_cnt;
  logic [2:0] idx_next;

  assign idx_next = idx - 3'd1;

  // The state register describes the cycle currently being driven. All
  // outputs are computed together with the next state, so dout, busy, done
  // and frame_cnt are registered and line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= 3'd6;
      gap_cnt   <= 4'd0;
      dout      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= S_SEND;
            idx   <= 3'd6;
            dout  <= PATTERN[6];
            busy  <= 1'b1;
          end else begin
            dout <= 1'b1;
            busy <= 1'b0;
          end
        end

        S_SEND: begin
          busy <= 1'b1;
          if (idx == 3'd0) begin
            // Last bit is on the line now; the next cycle is the first gap
            // cycle, which carries the done pulse and the counter update.
            state     <= S_GAP;
            gap_cnt   <= 4'd0;
            dout      <= 1'b1;
            done      <= 1'b1;
            frame_cnt <= frame_cnt + 8'd1;
          end else begin
            idx  <= idx_next;
            dout <= PATTERN[idx_next];
            done <= 1'b0;
          end
        end

        S_GAP: begin
          done <= 1'b0;
          if (gap_cnt == GAP_LAST) begin
`ifdef XL_SENDER_BURST_EN
            if (start) begin
              state <= S_SEND;
              idx   <= 3'd6;
              dout  <= PATTERN[6];
              busy  <= 1'b1;
            end else begin
              state <= S_IDLE;
              dout  <= 1'b1;
              busy  <= 1'b0;
            end
`else
            state <= S_IDLE;
            dout  <= 1'b1;
            busy  <= 1'b0;
`endif
            gap_cnt <= 4'd0;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
            dout    <= 1'b1;
            busy    <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          dout  <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xl_sender.sv
// -----------------------------------------------------------------------------
// tb_xl_sender
//
// Purpose:
//   Self-checking bench for xl_sender. Two instances share clk/rst/start: one
//   with the default PATTERN and one with PATTERN = 7'b111_0001. A reference
//   model keeps a queue of frame slot positions (0..6 = frame bits, 7.. =
//   gap cycles, -1 = idle); expected outputs of each instance are derived from
//   the current slot and that instance's pattern.
//
// Configuration:
//   XL_SENDER_BURST_EN  must match the define used for the RTL build.
// -----------------------------------------------------------------------------
module tb_xl_sender;

  localparam logic [6:0] PAT_A = 7'b010_0010;
  localparam logic [6:0] PAT_B = 7'b111_0001;
  localparam int         GAP   = 2;
  localparam int         LAST  = 6 + GAP;
`ifdef XL_SENDER_BURST_EN
  localparam int         PERIOD = 7 + GAP;
  localparam bit         BURST  = 1'b1;
`else
  localparam int         PERIOD = 7 + GAP + 1;
  localparam bit         BURST  = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       start;
  logic       dout;
  logic       busy;
  logic       done;
  logic [7:0] frame_cnt;
  logic       dout_b;
  logic       busy_b;
  logic       done_b;
  logic [7:0] frame_cnt_b;

  int errors;
  int checks;
  int cyc;

  // Reference model state
  int         cur_pos;
  int         slot_q[$];
  logic [7:0] exp_cnt;

  xl_sender #(.PATTERN(PAT_A), .GAP(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dout      (dout),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt)
  );

  xl_sender #(.PATTERN(PAT_B), .GAP(GAP)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dout      (dout_b),
    .busy      (busy_b),
    .done      (done_b),
    .frame_cnt (frame_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic expDout(input logic [6:0] pat, input int pos);
    if (pos >= 0 && pos < 7) return pat[6 - pos];
    return 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h",
             tag, cyc, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic modelEdge(input logic s, input logic r);
    if (r) begin
      slot_q.delete();
      cur_pos = -1;
      exp_cnt = 8'd0;
    end else begin
      if (s && (cur_pos < 0 || (BURST && cur_pos == LAST))) begin
        for (int p = 0; p <= LAST; p++) slot_q.push_back(p);
      end
      if (slot_q.size() > 0) cur_pos = slot_q.pop_front();
      else cur_pos = -1;
      if (cur_pos == 7) exp_cnt = exp_cnt + 8'd1;
    end
  endtask

  task automatic compareAll();
    checkOutput("dout",        {31'd0, dout},        {31'd0, expDout(PAT_A, cur_pos)});
    checkOutput("busy",        {31'd0, busy},        {31'd0, cur_pos >= 0});
    checkOutput("done",        {31'd0, done},        {31'd0, cur_pos == 7});
    checkOutput("frame_cnt",   {24'd0, frame_cnt},   {24'd0, exp_cnt});
    checkOutput("dout_b",      {31'd0, dout_b},      {31'd0, expDout(PAT_B, cur_pos)});
    checkOutput("frame_cnt_b", {24'd0, frame_cnt_b}, {24'd0, exp_cnt});
  endtask

  // Drive one cycle of inputs, take the edge, then check 1 time unit later.
  task automatic applyStimulus(input logic s, input logic r);
    start = s;
    rst   = r;
    @(posedge clk);
    modelEdge(s, r);
    #1;
    cyc++;
    compareAll();
  endtask

  logic [8:0] seq_a;
  logic [8:0] seq_b;
  int         last_done;
  int         n_done;
  int         guard;

  initial begin
    errors  = 0;
    checks  = 0;
    cyc     = 0;
    cur_pos = -1;
    exp_cnt = 8'd0;
    start   = 1'b0;
    rst     = 1'b1;

    // Scenario 1: reset, single start pulse, explicit waveform
    $display("[TB] scenario 1: single frame");
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("reset_dout", {31'd0, dout}, 32'd1);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_cnt",  {24'd0, frame_cnt}, 32'd0);
    applyStimulus(1'b0, 1'b0);
    seq_a = 9'b0_1000_1011;
    seq_b = 9'b1_1100_0111;
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      checkOutput("s1_dout",   {31'd0, dout},   {31'd0, seq_a[8 - i]});
      checkOutput("s1_dout_b", {31'd0, dout_b}, {31'd0, seq_b[8 - i]});
      checkOutput("s1_busy",   {31'd0, busy},   32'd1);
      checkOutput("s1_done",   {31'd0, done},   {31'd0, i == 7});
      applyStimulus(1'b0, 1'b0);
    end
    checkOutput("s1_busy_end", {31'd0, busy}, 32'd0);
    checkOutput("s1_cnt",      {24'd0, frame_cnt}, 32'd1);

    // Scenario 2/3: start held for 40 cycles
    $display("[TB] scenario 2/3: held start");
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    last_done = -1;
    n_done    = 0;
    for (int k = 1; k <= 40; k++) begin
      applyStimulus(1'b1, 1'b0);
      if (done) begin
        n_done++;
        if (last_done >= 0)
          checkOutput("done_period", cyc - last_done, PERIOD);
        last_done = cyc;
      end
      if (BURST) checkOutput("burst_busy", {31'd0, busy}, 32'd1);
    end
    checkOutput("held_dones", n_done, 32'd4);
    checkOutput("held_cnt",   {24'd0, frame_cnt}, 32'd4);
    for (int k = 0; k < 15; k++) applyStimulus(1'b0, 1'b0);

    // Scenario 4: reset in the middle of a frame (bit index 3)
    $display("[TB] scenario 4: reset mid-frame");
    applyStimulus(1'b1, 1'b0);
    guard = 0;
    while (cur_pos != 3 && guard < 20) begin
      applyStimulus(1'b0, 1'b0);
      guard++;
    end
    checkOutput("s4_reach", {31'd0, cur_pos == 3}, 32'd1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("s4_dout", {31'd0, dout}, 32'd1);
    checkOutput("s4_busy", {31'd0, busy}, 32'd0);
    checkOutput("s4_cnt",  {24'd0, frame_cnt}, 32'd0);
    n_done = 0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0);
      if (done) n_done++;
    end
    checkOutput("s4_no_done", n_done, 32'd0);
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      checkOutput("s4_refrm", {31'd0, dout}, {31'd0, seq_a[8 - i]});
      applyStimulus(1'b0, 1'b0);
    end
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b0);
    checkOutput("s4_cnt_after", {24'd0, frame_cnt}, 32'd1);

    // Scenario 5: start pulses during SEND bit 2 and the first gap cycle
    $display("[TB] scenario 5: ignored starts");
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus((cur_pos == 4 || cur_pos == 7) ? 1'b1 : 1'b0, 1'b0);
      if (done) n_done++;
    end
    checkOutput("s5_dones", n_done, 32'd1);
    checkOutput("s5_cnt",   {24'd0, frame_cnt}, 32'd1);

    // Randomized traffic with occasional resets
    $display("[TB] random phase");
    for (int k = 0; k < 400; k++)
      applyStimulus(($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) < 2)  ? 1'b1 : 1'b0);

    // Scenario 6: 256 frames, counter wraps to 0
    $display("[TB] scenario 6: counter wrap");
    applyStimulus(1'b0, 1'b1);
    n_done = 0;
    for (int k = 0; k < 3000 && n_done < 256; k++) begin
      applyStimulus(1'b1, 1'b0);
      if (cur_pos == 7) begin
        n_done++;
        if (n_done == 255) checkOutput("cnt_255",  {24'd0, frame_cnt}, 32'd255);
        if (n_done == 256) checkOutput("cnt_wrap", {24'd0, frame_cnt}, 32'd0);
      end
    end
    checkOutput("wrap_reached", n_done, 32'd256);
    for (int k = 0; k < 15; k++) applyStimulus(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
